zap_predecode_fifo: RTL and testbench

ZAP_PREDECODE_FIFO -- requirements
Module: zap_predecode_fifo

---
 rtl/zap_pkg.sv | 16 +
 rtl/zap_predecode_fifo_mem.sv | 29 ++
 rtl/zap_predecode_fifo.sv | 102 ++++++++++
 tb/tb_zap_predecode_fifo.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/zap_pkg.sv
// Shared fetch-side types: the fetch packet as produced by fetch and consumed
// by the predecode FIFO and the mode16 decoder.
package zap_pkg;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_ff;
        logic [31:0] pc_plus_8_ff;
        logic [1:0]  taken;
        logic [32:0] pred;
        logic        iabort;
    } zap_fetch_pkt_t;

    localparam int ZAP_FETCH_PKT_W = $bits(zap_fetch_pkt_t);

endpackage

// File: rtl/zap_predecode_fifo_mem.sv
// Packet storage for the predecode FIFO: one synchronous write port, one
// asynchronous read port, cleared to zero on reset.
module zap_predecode_fifo_mem
    import zap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_we,
    input  logic [$clog2(DEPTH)-1:0]   i_waddr,
    input  zap_fetch_pkt_t             i_wdata,
    input  logic [$clog2(DEPTH)-1:0]   i_raddr,
    output zap_fetch_pkt_t             o_rdata
);

    zap_fetch_pkt_t r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/zap_predecode_fifo.sv
// Fetch-to-decode packet FIFO with flush support. Define
// ZAP_PREDECODE_FIFO_BYPASS_EN to forward a push into an empty FIFO same-cycle.
module zap_predecode_fifo
    import zap_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear_from_writeback,
    input  logic        i_clear_from_alu,
    input  logic        i_clear_from_decode,
    input  logic        i_wr_en,
    input  logic [31:0] i_instruction,
    input  logic [31:0] i_pc_ff,
    input  logic [31:0] i_pc_plus_8_ff,
    input  logic [1:0]  i_taken,
    input  logic [32:0] i_pred,
    input  logic        i_iabort,
    output logic        o_full,
    input  logic        i_stall,
    output logic [31:0] o_instruction,
    output logic [31:0] o_pc_ff,
    output logic [31:0] o_pc_plus_8_ff,
    output logic [1:0]  o_taken,
    output logic [32:0] o_pred,
    output logic        o_iabort,
    output logic        o_instruction_valid
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]    r_wr_ptr, r_rd_ptr;
    logic [AW:0]    w_wr_ptr_nxt, w_rd_ptr_nxt;
    logic           r_full, w_full_nxt;
    logic           w_empty, w_push, w_pop, w_clear;
    zap_fetch_pkt_t w_in_pkt, w_head_pkt, w_out_pkt;

    assign w_in_pkt.instruction  = i_instruction;
    assign w_in_pkt.pc_ff        = i_pc_ff;
    assign w_in_pkt.pc_plus_8_ff = i_pc_plus_8_ff;
    assign w_in_pkt.taken        = i_taken;
    assign w_in_pkt.pred         = i_pred;
    assign w_in_pkt.iabort       = i_iabort;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_clear = i_clear_from_writeback | i_clear_from_alu | i_clear_from_decode;
    assign w_pop   = !w_empty && !i_stall;

`ifdef ZAP_PREDECODE_FIFO_BYPASS_EN
    // A bypassed packet consumed this cycle never needs a storage slot.
    assign w_push              = i_wr_en && !r_full && !(w_empty && !i_stall);
    assign w_out_pkt           = (w_empty && i_wr_en) ? w_in_pkt : w_head_pkt;
    assign o_instruction_valid = !w_empty || i_wr_en;
`else
    assign w_push              = i_wr_en && !r_full;
    assign w_out_pkt           = w_head_pkt;
    assign o_instruction_valid = !w_empty;
`endif

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
        w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};
        if (w_clear) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
        end
        w_full_nxt = (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]) &&
                     (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_full   <= w_full_nxt;
        end
    end

    zap_predecode_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_we    (w_push && !w_clear),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_in_pkt),
        .i_raddr (r_rd_ptr[AW-1:0]),
        .o_rdata (w_head_pkt)
    );

    assign o_full         = r_full;
    assign o_instruction  = w_out_pkt.instruction;
    assign o_pc_ff        = w_out_pkt.pc_ff;
    assign o_pc_plus_8_ff = w_out_pkt.pc_plus_8_ff;
    assign o_taken        = w_out_pkt.taken;
    assign o_pred         = w_out_pkt.pred;
    assign o_iabort       = w_out_pkt.iabort;

endmodule

// File: tb/tb_zap_predecode_fifo.sv
// Directed bench for zap_predecode_fifo (DEPTH=4); bypass steps build only
// when ZAP_PREDECODE_FIFO_BYPASS_EN is defined.
module tb_zap_predecode_fifo;

    logic        i_clk = 1'b0;
    logic        i_reset, i_clear_from_writeback, i_clear_from_alu, i_clear_from_decode;
    logic        i_wr_en, i_stall, i_iabort;
    logic [31:0] i_instruction, i_pc_ff, i_pc_plus_8_ff;
    logic [1:0]  i_taken;
    logic [32:0] i_pred;
    logic        o_full, o_iabort, o_instruction_valid;
    logic [31:0] o_instruction, o_pc_ff, o_pc_plus_8_ff;
    logic [1:0]  o_taken;
    logic [32:0] o_pred;

    int checks = 0;
    int fails  = 0;

    zap_predecode_fifo #(.DEPTH(4)) dut (
        .i_clk                  (i_clk),
        .i_reset                (i_reset),
        .i_clear_from_writeback (i_clear_from_writeback),
        .i_clear_from_alu       (i_clear_from_alu),
        .i_clear_from_decode    (i_clear_from_decode),
        .i_wr_en                (i_wr_en),
        .i_instruction          (i_instruction),
        .i_pc_ff                (i_pc_ff),
        .i_pc_plus_8_ff         (i_pc_plus_8_ff),
        .i_taken                (i_taken),
        .i_pred                 (i_pred),
        .i_iabort               (i_iabort),
        .o_full                 (o_full),
        .i_stall                (i_stall),
        .o_instruction          (o_instruction),
        .o_pc_ff                (o_pc_ff),
        .o_pc_plus_8_ff         (o_pc_plus_8_ff),
        .o_taken                (o_taken),
        .o_pred                 (o_pred),
        .o_iabort               (o_iabort),
        .o_instruction_valid    (o_instruction_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Payload sidebands are derived from the instruction and pc so every
    // field of the packet is distinct and checkable.
    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        i_instruction  = instr;
        i_pc_ff        = pc;
        i_pc_plus_8_ff = pc + 32'd8;
        i_taken        = instr[1:0];
        i_pred         = {instr[2], pc};
        i_iabort       = instr[3];
    endtask

    task automatic check_head(input string tag, input logic [31:0] instr, input logic [31:0] pc);
        chk({tag, "_valid"}, 64'(o_instruction_valid), 64'd1);
        chk({tag, "_instr"}, 64'(o_instruction), 64'(instr));
        chk({tag, "_pc"},    64'(o_pc_ff), 64'(pc));
        chk({tag, "_pc8"},   64'(o_pc_plus_8_ff), 64'(pc + 32'd8));
        chk({tag, "_taken"}, 64'(o_taken), 64'(instr[1:0]));
        chk({tag, "_pred"},  64'(o_pred), 64'({instr[2], pc}));
        chk({tag, "_abort"}, 64'(o_iabort), 64'(instr[3]));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, 64'(o_instruction_valid), 64'd0);
        chk({tag, "_full"},  64'(o_full), 64'd0);
        chk({tag, "_instr"}, 64'(o_instruction), 64'd0);
        chk({tag, "_pc"},    64'(o_pc_ff), 64'd0);
        chk({tag, "_pc8"},   64'(o_pc_plus_8_ff), 64'd0);
        chk({tag, "_taken"}, 64'(o_taken), 64'd0);
        chk({tag, "_pred"},  64'(o_pred), 64'd0);
        chk({tag, "_abort"}, 64'(o_iabort), 64'd0);
    endtask

    initial begin
        i_reset = 1'b1;
        i_clear_from_writeback = 1'b0;
        i_clear_from_alu = 1'b0;
        i_clear_from_decode = 1'b0;
        i_wr_en = 1'b0;
        i_stall = 1'b0;
        drive(32'h0, 32'h0);
        tick;
        tick;
        i_reset = 1'b0;
        #1;
        check_zero("reset");

        // Single packet, no stall
        drive(32'hE3A00001, 32'h100);
        i_wr_en = 1'b1;
        #1;
`ifdef ZAP_PREDECODE_FIFO_BYPASS_EN
        check_head("t1_byp", 32'hE3A00001, 32'h100);
        tick;
        i_wr_en = 1'b0;
        #1;
        chk("t1_empty", 64'(o_instruction_valid), 64'd0);
`else
        chk("t1_no_comb_valid", 64'(o_instruction_valid), 64'd0);
        tick;
        i_wr_en = 1'b0;
        #1;
        check_head("t1_head", 32'hE3A00001, 32'h100);
        tick;
        chk("t1_popped", 64'(o_instruction_valid), 64'd0);
`endif

        // Fill under stall; fifth push must be rejected
        i_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(32'hA0000000 + i, 32'h2000 + 4 * i);
            i_wr_en = 1'b1;
            tick;
            chk("t2_full", 64'(o_full), (i >= 3) ? 64'd1 : 64'd0);
        end
        i_wr_en = 1'b0;
        #1;
        check_head("t2_hold0", 32'hA0000000, 32'h2000);
        tick;
        check_head("t2_hold1", 32'hA0000000, 32'h2000);
        i_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_head("t2_drain", 32'hA0000000 + i, 32'h2000 + 4 * i);
            tick;
        end
        chk("t2_end_valid", 64'(o_instruction_valid), 64'd0);
        chk("t2_end_full", 64'(o_full), 64'd0);

        // Streaming push+pop across pointer wrap
        for (int k = 0; k < 10; k++) begin
            drive(32'hB0000000 + k, 32'h3000 + 4 * k);
            i_wr_en = 1'b1;
            #1;
`ifdef ZAP_PREDECODE_FIFO_BYPASS_EN
            check_head("t3_byp", 32'hB0000000 + k, 32'h3000 + 4 * k);
`else
            if (k > 0) check_head("t3_stream", 32'hB0000000 + k - 1, 32'h3000 + 4 * (k - 1));
            chk("t3_full", 64'(o_full), 64'd0);
`endif
            tick;
        end
        i_wr_en = 1'b0;
        #1;
`ifndef ZAP_PREDECODE_FIFO_BYPASS_EN
        check_head("t3_last", 32'hB0000009, 32'h3000 + 4 * 9);
        tick;
`endif
        chk("t3_end_valid", 64'(o_instruction_valid), 64'd0);

        // ALU flush with same-cycle push and pop
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(32'hC0000000 + i, 32'h4000 + 4 * i);
            i_wr_en = 1'b1;
            tick;
        end
        drive(32'hC0000003, 32'h400C);
        i_stall = 1'b0;
        i_clear_from_alu = 1'b1;
        tick;
        i_clear_from_alu = 1'b0;
        i_wr_en = 1'b0;
        #1;
        chk("t4_clr_valid", 64'(o_instruction_valid), 64'd0);
        chk("t4_clr_full", 64'(o_full), 64'd0);
        tick;
        chk("t4_clr_valid2", 64'(o_instruction_valid), 64'd0);
        i_stall = 1'b1;
        drive(32'hD0000000, 32'h5000);
        i_wr_en = 1'b1;
        tick;
        i_wr_en = 1'b0;
        #1;
        check_head("t4_after", 32'hD0000000, 32'h5000);
        i_stall = 1'b0;
        tick;
        chk("t4_after_pop", 64'(o_instruction_valid), 64'd0);

        // Writeback flush while full, decode flush with one entry
        i_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(32'hD1000000 + i, 32'h6000 + 4 * i);
            i_wr_en = 1'b1;
            tick;
        end
        i_wr_en = 1'b0;
        chk("t4_wb_pre_full", 64'(o_full), 64'd1);
        i_clear_from_writeback = 1'b1;
        tick;
        i_clear_from_writeback = 1'b0;
        #1;
        chk("t4_wb_valid", 64'(o_instruction_valid), 64'd0);
        chk("t4_wb_full", 64'(o_full), 64'd0);
        drive(32'hD2000000, 32'h7000);
        i_wr_en = 1'b1;
        tick;
        i_wr_en = 1'b0;
        i_clear_from_decode = 1'b1;
        tick;
        i_clear_from_decode = 1'b0;
        #1;
        chk("t4_dec_valid", 64'(o_instruction_valid), 64'd0);

        // Reset while full and stalled, with a push pending
        for (int i = 0; i < 4; i++) begin
            drive(32'hE0000000 + i, 32'h8000 + 4 * i);
            i_wr_en = 1'b1;
            tick;
        end
        chk("t5_pre_full", 64'(o_full), 64'd1);
        i_reset = 1'b1;
        drive(32'hEF00000F, 32'h8FF0);
        tick;
        i_reset = 1'b0;
        i_wr_en = 1'b0;
        #1;
        check_zero("t5_reset");

`ifdef ZAP_PREDECODE_FIFO_BYPASS_EN
        // Same-cycle forward into an empty FIFO
        i_stall = 1'b0;
        drive(32'h0000467B, 32'h400);
        i_wr_en = 1'b1;
        #1;
        check_head("t6_byp", 32'h0000467B, 32'h400);
        tick;
        i_wr_en = 1'b0;
        #1;
        chk("t6_empty", 64'(o_instruction_valid), 64'd0);
        i_stall = 1'b1;
        drive(32'h0000467C, 32'h404);
        i_wr_en = 1'b1;
        #1;
        check_head("t6_byp_stall", 32'h0000467C, 32'h404);
        tick;
        i_wr_en = 1'b0;
        #1;
        check_head("t6_stored", 32'h0000467C, 32'h404);
        i_stall = 1'b0;
        tick;
        chk("t6_drained", 64'(o_instruction_valid), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
